// File: rtl/sr_cmd_driver_if.sv
// Request handshake between a command source and sr_cmd_driver.
// The master drives req_valid/req_op; the driver answers with req_ready.
interface sr_cmd_driver_if;
    logic       req_valid;
    logic [1:0] req_op;
    logic       req_ready;

    modport master (output req_valid, output req_op, input req_ready);
    modport slave  (input req_valid, input req_op, output req_ready);
endinterface

// File: rtl/sr_cmd_driver.sv
// Turns handshaked hold/clear/set/toggle requests into non-overlapping set/reset pulses
// for an SR flop and tracks its expected state. Define SR_CMD_VERIFY_EN to add q readback with retry.
module sr_cmd_driver #(
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 2,
    parameter int RETRY_MAX  = 3,
    parameter int INIT_CLEAR = 1
) (
    input  logic             clk,
    input  logic             rst,
    sr_cmd_driver_if.slave   req,
    output logic             set_o,
    output logic             reset_o,
    input  logic             q_fb,
    output logic             tracked_q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE,
        ST_CHECK
    } state_e;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_CLEAR  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CW      = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;
    localparam int RW      = ($clog2(RETRY_MAX + 1) > 0) ? $clog2(RETRY_MAX + 1) : 1;

    localparam logic [CW-1:0] PULSE_LAST  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            target_q, target_d;
    logic            init_q, init_d;
    logic            trk_q, trk_d;
    logic            set_q, set_d;
    logic            reset_q, reset_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            strobe_d;

`ifdef SR_CMD_VERIFY_EN
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        target_d = target_q;
        init_d   = init_q;
        trk_d    = trk_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_INIT: begin
                // The power-up clear reuses the normal clear path; init_q suppresses its done pulse.
                target_d = 1'b0;
                init_d   = 1'b1;
                retry_d  = '0;
                cnt_d    = '0;
                strobe_d = 1'b1;
                state_d  = ST_PULSE;
            end

            ST_IDLE: begin
                if (req.req_valid && ready_q) begin
                    retry_d = '0;
                    cnt_d   = '0;
                    init_d  = 1'b0;
                    case (req.req_op)
                        OP_CLEAR:  target_d = 1'b0;
                        OP_SET:    target_d = 1'b1;
                        OP_TOGGLE: target_d = ~trk_q;
                        default:   target_d = target_q;
                    endcase
                    if (req.req_op == OP_HOLD) begin
                        done_d = 1'b1;
                    end else begin
                        strobe_d = 1'b1;
                        state_d  = ST_PULSE;
                    end
                end
            end

            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    strobe_d = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
`ifdef SR_CMD_VERIFY_EN
                    state_d = ST_CHECK;
`else
                    trk_d   = target_q;
                    done_d  = ~init_q;
                    state_d = ST_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef SR_CMD_VERIFY_EN
            ST_CHECK: begin
                if (q_fb == target_q) begin
                    trk_d   = target_q;
                    done_d  = ~init_q;
                    state_d = ST_IDLE;
                end else if (retry_q < RETRY_LIM) begin
                    retry_d  = retry_q + 1'b1;
                    strobe_d = 1'b1;
                    state_d  = ST_PULSE;
                end else begin
                    // Out of retries: believe the flop rather than the request.
                    err_d   = 1'b1;
                    trk_d   = q_fb;
                    state_d = ST_IDLE;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Both strobes derive from one enable and the target bit, so they can never be high together.
        set_d   = strobe_d & target_d;
        reset_d = strobe_d & ~target_d;
        ready_d = (state_d == ST_IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state_q  <= (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;
            cnt_q    <= '0;
            retry_q  <= '0;
            target_q <= 1'b0;
            init_q   <= 1'b0;
            trk_q    <= 1'b0;
            set_q    <= 1'b0;
            reset_q  <= 1'b0;
            ready_q  <= (INIT_CLEAR == 0);
            busy_q   <= (INIT_CLEAR != 0);
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            target_q <= target_d;
            init_q   <= init_d;
            trk_q    <= trk_d;
            set_q    <= set_d;
            reset_q  <= reset_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign req.req_ready = ready_q;
    assign set_o         = set_q;
    assign reset_o       = reset_q;
    assign tracked_q     = trk_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver: vector table for single requests plus hand sequences
// for the power-up clear, reset during a pulse and (verify build) a stuck flop.
module tb_sr_cmd_driver;

`ifdef SR_CMD_VERIFY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int LAT = 5 + EXTRA;

    logic clk = 1'b0;
    logic rst;
    logic set_o, reset_o, q_fb, tracked_q, busy, done, err;

    always #5 clk = ~clk;

    sr_cmd_driver_if rif ();

    sr_cmd_driver dut (
        .clk       (clk),
        .rst       (rst),
        .req       (rif),
        .set_o     (set_o),
        .reset_o   (reset_o),
        .q_fb      (q_fb),
        .tracked_q (tracked_q),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // Downstream SR flop model, sampling on the falling edge.
    logic flop_q  = 1'b0;
    logic stuck0  = 1'b0;
    logic overlap = 1'b0;

    always @(negedge clk) begin
        if (set_o) flop_q <= 1'b1;
        else if (reset_o) flop_q <= 1'b0;
        if (set_o && reset_o) overlap <= 1'b1;
    end

    assign q_fb = stuck0 ? 1'b0 : flop_q;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        int         exp_set;
        int         exp_rst;
        int         exp_lat;
        logic       exp_trk;
        string      name;
    } vec_t;

    vec_t vecs [9];

    task automatic wait_ready(output int waited);
        waited = 0;
        while (!rif.req_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
    endtask

    // Issue one request starting mid-cycle; observe up to 60 cycles after the accept edge.
    task automatic run_req(input logic [1:0] op, output int set_cyc, output int rst_cyc,
                           output int set_pulses, output int done_lat, output int err_lat,
                           output int rdy_end);
        logic prev_set;
        set_cyc = 0; rst_cyc = 0; set_pulses = 0; done_lat = 0; err_lat = 0; rdy_end = 0;
        prev_set = 1'b0;
        rif.req_valid = 1'b1;
        rif.req_op    = op;
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (set_o) set_cyc++;
            if (set_o && !prev_set) set_pulses++;
            prev_set = set_o;
            if (reset_o) rst_cyc++;
            if (done || err) begin
                if (done) done_lat = k;
                if (err) err_lat = k;
                rdy_end = int'(rif.req_ready);
                break;
            end
        end
    endtask

    // Called at a negedge right after rst is released.
    task automatic init_seq(input string tag);
        int rst_cyc, set_cyc, rdy_k, done_n, err_n;
        rst_cyc = 0; set_cyc = 0; rdy_k = 0; done_n = 0; err_n = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (reset_o) rst_cyc++;
            if (set_o) set_cyc++;
            if (done) done_n++;
            if (err) err_n++;
            if (rif.req_ready && rdy_k == 0) rdy_k = k;
        end
        check({tag, "_reset_cycles"}, rst_cyc, 2);
        check({tag, "_set_cycles"}, set_cyc, 0);
        check({tag, "_ready_cycle"}, rdy_k, 5 + EXTRA);
        check({tag, "_done_pulses"}, done_n, 0);
        check({tag, "_err_pulses"}, err_n, 0);
        check({tag, "_tracked"}, int'(tracked_q), 0);
        check({tag, "_busy_idle"}, int'(busy), 0);
    endtask

    initial begin
        int waited, sc, rc, sp, dl, el, rdy;

        vecs[0] = '{2'b10, 2, 0, LAT, 1'b1, "set"};
        vecs[1] = '{2'b11, 0, 2, LAT, 1'b0, "toggle_1to0"};
        vecs[2] = '{2'b11, 2, 0, LAT, 1'b1, "toggle_0to1"};
        vecs[3] = '{2'b00, 0, 0, 1,   1'b1, "hold_at1"};
        vecs[4] = '{2'b10, 2, 0, LAT, 1'b1, "set_redundant"};
        vecs[5] = '{2'b01, 0, 2, LAT, 1'b0, "clear"};
        vecs[6] = '{2'b01, 0, 2, LAT, 1'b0, "clear_redundant"};
        vecs[7] = '{2'b00, 0, 0, 1,   1'b0, "hold_at0"};
        vecs[8] = '{2'b11, 2, 0, LAT, 1'b1, "toggle_final"};

        rif.req_valid = 1'b0;
        rif.req_op    = 2'b00;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_set_o", int'(set_o), 0);
        check("rst_reset_o", int'(reset_o), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_tracked", int'(tracked_q), 0);
        check("rst_ready", int'(rif.req_ready), 0);
        check("rst_busy", int'(busy), 1);
        rst = 1'b0;
        init_seq("init");

        for (int i = 0; i < 9; i++) begin
            wait_ready(waited);
            check({vecs[i].name, "_wait"}, waited, 0);
            run_req(vecs[i].op, sc, rc, sp, dl, el, rdy);
            check({vecs[i].name, "_set_cycles"}, sc, vecs[i].exp_set);
            check({vecs[i].name, "_reset_cycles"}, rc, vecs[i].exp_rst);
            check({vecs[i].name, "_done_cycle"}, dl, vecs[i].exp_lat);
            check({vecs[i].name, "_err_cycle"}, el, 0);
            check({vecs[i].name, "_tracked"}, int'(tracked_q), int'(vecs[i].exp_trk));
            check({vecs[i].name, "_ready_at_done"}, rdy, 1);
        end

        // Reset while a set pulse is on the wire.
        wait_ready(waited);
        rif.req_valid = 1'b1;
        rif.req_op    = 2'b10;
        @(posedge clk);
        #1;
        rif.req_valid = 1'b0;
        @(negedge clk);
        check("midrst_pulse_on", int'(set_o), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_set_o", int'(set_o), 0);
        check("midrst_reset_o", int'(reset_o), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_tracked", int'(tracked_q), 0);
        check("midrst_busy", int'(busy), 1);
        rst = 1'b0;
        init_seq("reinit");

`ifdef SR_CMD_VERIFY_EN
        // Flop output stuck low: 1 + RETRY_MAX set pulses, then err instead of done.
        stuck0 = 1'b1;
        wait_ready(waited);
        run_req(2'b10, sc, rc, sp, dl, el, rdy);
        check("stuck_set_pulses", sp, 4);
        check("stuck_set_cycles", sc, 8);
        check("stuck_reset_cycles", rc, 0);
        check("stuck_err_cycle", el, 21);
        check("stuck_done_cycle", dl, 0);
        check("stuck_tracked", int'(tracked_q), 0);
        @(negedge clk);
        check("stuck_err_one_cycle", int'(err), 0);
`endif

        check("no_set_reset_overlap", int'(overlap), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
